// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, sequencer states and bit-reversal helper for the FFT frame loader
package fft_pkg;

    localparam int LOG2N_MAX = 12;
    localparam int RAM_AW    = 12;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_UNLOAD
    } fft_state_e;

    // Reverse the full RAM_AW-bit word, then shift so only the low `width` bits remain reversed.
    function automatic logic [RAM_AW-1:0] bitrev(input logic [RAM_AW-1:0] v, input int width);
        logic [RAM_AW-1:0] r;
        for (int i = 0; i < RAM_AW; i++) begin
            r[i] = v[RAM_AW-1-i];
        end
        return r >> (RAM_AW - width);
    endfunction

endpackage

// File: rtl/fft_out_skid.sv
// rtl/fft_out_skid.sv - 2-entry result buffer with per-entry last flag; an arriving word passes straight through when empty
module fft_out_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_tdata,
    input  logic        i_tvalid,
    input  logic        i_tlast,
    output logic [31:0] o_tdata,
    output logic        o_tvalid,
    output logic        o_tlast,
    input  logic        i_tready,
    output logic [1:0]  o_count
);

    logic [31:0] r_data [2];
    logic [1:0]  r_last;
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic w_empty;
    logic w_push;
    logic w_pop_mem;

    assign w_empty   = (r_count == 2'd0);
    assign o_tvalid  = !w_empty || i_tvalid;
    assign o_tdata   = !w_empty ? r_data[r_rptr] : (i_tvalid ? i_tdata : 32'd0);
    assign o_tlast   = !w_empty ? r_last[r_rptr] : (i_tvalid & i_tlast);
    // A word is stored unless it bypasses an empty buffer and is taken the same cycle.
    assign w_push    = i_tvalid && !(w_empty && i_tready);
    assign w_pop_mem = !w_empty && i_tready;
    assign o_count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= i_tdata;
                r_last[r_wptr] <= i_tlast;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop_mem) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop_mem};
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - load a frame into the FFT RAM, run the engine, stream results out; FFT_BITREV_EN selects bit-reversed load order
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [15:0]       ram_data_in,
    output logic [RAM_AW-1:0] ram_adr,
    output logic              ram_write,
    output logic              ram_read,
    input  logic [31:0]       ram_data_out,
    output logic              mode,
    output logic              fft_start,
    input  logic              fft_done
);

    localparam logic [LOG2N-1:0] LAST = '1;

    fft_state_e        r_state;
    fft_state_e        w_state_nxt;
    logic [LOG2N-1:0]  r_cnt;
    logic [LOG2N-1:0]  r_rd_cnt;
    logic              r_live;
    logic              r_rd_done;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_wr;
    logic              w_rd;
    logic              w_pop;
    logic [1:0]        w_buf_cnt;
    logic [2:0]        w_occ;
    logic [RAM_AW-1:0] w_wr_adr;

`ifdef FFT_BITREV_EN
    assign w_wr_adr = bitrev(RAM_AW'(r_cnt), LOG2N);
`else
    assign w_wr_adr = RAM_AW'(r_cnt);
`endif

    assign w_pop = m_tvalid & m_tready;
    assign w_occ = {2'b00, r_inflight} + {1'b0, w_buf_cnt};

    always_comb begin
        w_state_nxt = r_state;
        s_tready    = 1'b0;
        ram_write   = 1'b0;
        ram_read    = 1'b0;
        ram_adr     = '0;
        ram_data_in = '0;
        mode        = 1'b1;
        fft_start   = 1'b0;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        case (r_state)
            ST_LOAD: begin
                s_tready  = r_live;
                w_wr      = s_tvalid & r_live;
                ram_write = w_wr;
                if (w_wr) begin
                    ram_adr     = w_wr_adr;
                    ram_data_in = s_tdata;
                    if (r_cnt == LAST) begin
                        w_state_nxt = ST_START;
                    end
                end
            end
            ST_START: begin
                mode        = 1'b0;
                fft_start   = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                mode = 1'b0;
                if (fft_done) begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                // Never let in-flight plus buffered words exceed the 2-entry buffer.
                w_rd     = !r_rd_done && (w_occ < (3'd2 + {2'b00, w_pop}));
                ram_read = w_rd;
                if (w_rd) begin
                    ram_adr = RAM_AW'(r_rd_cnt);
                end
                if (w_pop && m_tlast) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live          <= 1'b0;
            r_cnt           <= '0;
            r_rd_cnt        <= '0;
            r_rd_done       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_live          <= 1'b1;
            r_inflight      <= w_rd;
            r_inflight_last <= w_rd && (r_rd_cnt == LAST);
            if (w_wr) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
            if (w_rd) begin
                r_rd_cnt <= (r_rd_cnt == LAST) ? '0 : r_rd_cnt + 1'b1;
                if (r_rd_cnt == LAST) begin
                    r_rd_done <= 1'b1;
                end
            end
            if (r_state == ST_UNLOAD && w_pop && m_tlast) begin
                r_rd_done <= 1'b0;
                r_rd_cnt  <= '0;
            end
        end
    end

    fft_out_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_tdata  (ram_data_out),
        .i_tvalid (r_inflight),
        .i_tlast  (r_inflight_last),
        .o_tdata  (m_tdata),
        .o_tvalid (m_tvalid),
        .o_tlast  (m_tlast),
        .i_tready (m_tready),
        .o_count  (w_buf_cnt)
    );

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - scoreboard bench for fft_frame_loader with LOG2N=3
module tb_fft_frame_loader;

    localparam int LOG2N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_tdata = 16'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [15:0] ram_data_in;
    logic [11:0] ram_adr;
    logic        ram_write;
    logic        ram_read;
    logic [31:0] ram_data_out = 32'd0;
    logic        mode;
    logic        fft_start;
    logic        fft_done = 1'b0;

    typedef struct {
        logic [11:0] adr;
        logic [15:0] data;
    } wr_t;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } out_t;

    wr_t  wq[$];
    out_t oq[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_start = 0;
    int          issued = 0;
    int          consumed = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [31:0] rd_base = 32'hA000_0000;
    logic        pat_en = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          pk = 0;

`ifdef FFT_BITREV_EN
    int br_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`endif

    fft_frame_loader #(.LOG2N(LOG2N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .ram_data_in  (ram_data_in),
        .ram_adr      (ram_adr),
        .ram_write    (ram_write),
        .ram_read     (ram_read),
        .ram_data_out (ram_data_out),
        .mode         (mode),
        .fft_start    (fft_start),
        .fft_done     (fft_done)
    );

    always #5 clk = ~clk;

    // FFT results region: a read of address a returns rd_base + a one cycle later.
    always @(posedge clk) begin
        if (ram_read) ram_data_out <= rd_base + {20'd0, ram_adr};
    end

    always @(posedge clk) begin
        #1;
        if (pat_en) begin
            m_tready = pat[pk];
            pk = (pk + 1) % 4;
        end else begin
            m_tready = 1'b1;
            pk = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] exp_adr(input int i);
`ifdef FFT_BITREV_EN
        return 12'(br_tab[i]);
`else
        return 12'(i);
`endif
    endfunction

    always @(negedge clk) begin
        int   pop;
        wr_t  w;
        out_t o;
        if (!rst_n) begin
            issued     = 0;
            consumed   = 0;
            prev_stall = 1'b0;
        end else begin
            pop = (m_tvalid && m_tready) ? 1 : 0;
            if (ram_write) begin
                chk("wr_rd_exclusive", 32'(ram_read), 32'd0);
                if (wq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: adr %h data %h", ram_adr, ram_data_in);
                end else begin
                    w = wq.pop_front();
                    chk("wr_adr", 32'(ram_adr), 32'(w.adr));
                    chk("wr_data", 32'(ram_data_in), 32'(w.data));
                end
            end
            if (ram_read) begin
                chk("rd_pending_lt2", 32'((issued - consumed - pop) < 2), 32'd1);
                issued++;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(m_tvalid), 32'd1);
                chk("stall_data", m_tdata, prev_data);
            end
            if (pop == 1) begin
                if (oq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: data %h", m_tdata);
                end else begin
                    o = oq.pop_front();
                    chk("out_data", m_tdata, o.data);
                    chk("out_last", 32'(m_tlast), 32'(o.last));
                end
                n_out++;
                consumed++;
            end
            if (fft_start) n_start++;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", m_tdata, 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_ram_data_in", 32'(ram_data_in), 32'd0);
        chk("rst_ram_adr", 32'(ram_adr), 32'd0);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_ram_read", 32'(ram_read), 32'd0);
        chk("rst_mode", 32'(mode), 32'd1);
        chk("rst_fft_start", 32'(fft_start), 32'd0);
    endtask

    task automatic load_frame(input logic [15:0] base, input int cnt);
        wr_t w;
        for (int i = 0; i < cnt; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = base + 16'(i);
            w.adr    = exp_adr(i);
            w.data   = base + 16'(i);
            wq.push_back(w);
            step();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic chk_start();
        @(negedge clk);
        chk("start_pulse", 32'(fft_start), 32'd1);
        chk("start_mode", 32'(mode), 32'd0);
        chk("start_s_tready", 32'(s_tready), 32'd0);
        step();
        fft_done = 1'b0;
        @(negedge clk);
        chk("run_no_start", 32'(fft_start), 32'd0);
        chk("run_mode", 32'(mode), 32'd0);
    endtask

    task automatic push_outs(input logic [31:0] base);
        out_t o;
        for (int i = 0; i < 8; i++) begin
            o.data = base + 32'(i);
            o.last = (i == 7);
            oq.push_back(o);
        end
    endtask

    task automatic wait_outputs(input int target);
        int k = 0;
        while (n_out < target && k < 200) begin
            step();
            k++;
        end
        chk("unload_count", 32'(n_out), 32'(target));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk_reset_vals();
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("ready_after_reset", 32'(s_tready), 32'd1);
        step();

        // Frame 1: done during START ignored, later done held 5 cycles, stalled unload.
        load_frame(16'h0001, 8);
        fft_done = 1'b1;
        chk_start();
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("run_hold_mode", 32'(mode), 32'd0);
            chk("run_hold_rd", 32'(ram_read), 32'd0);
        end
        step();
        rd_base = 32'hA000_0000;
        push_outs(rd_base);
        n_out = 0;
        pat_en = 1'b1;
        fft_done = 1'b1;
        repeat (5) step();
        fft_done = 1'b0;
        wait_outputs(8);
        pat_en = 1'b0;
        repeat (3) step();
        chk("f1_out_total", 32'(n_out), 32'd8);
        chk("f1_oq_empty", 32'(oq.size()), 32'd0);
        chk("f1_start_count", 32'(n_start), 32'd1);
        @(negedge clk);
        chk("f1_back_load", 32'(s_tready), 32'd1);
        chk("f1_mode_host", 32'(mode), 32'd1);
        step();

        // Frame 2: latency and sustained rate with m_tready held high.
        load_frame(16'h0011, 8);
        chk_start();
        step();
        @(negedge clk);
        chk("f2_run_mode", 32'(mode), 32'd0);
        step();
        rd_base = 32'hB000_0000;
        push_outs(rd_base);
        n_out = 0;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        @(negedge clk);
        chk("f2_first_read", 32'(ram_read), 32'd1);
        chk("f2_mode_host", 32'(mode), 32'd1);
        chk("f2_no_valid_yet", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        chk("f2_first_valid", 32'(m_tvalid), 32'd1);
        chk("f2_first_data", m_tdata, 32'hB000_0000);
        repeat (7) @(negedge clk);
        #1;
        chk("f2_sustained_rate", 32'(n_out), 32'd8);
        step();
        chk("f2_oq_empty", 32'(oq.size()), 32'd0);
        chk("f2_start_count", 32'(n_start), 32'd2);

        // Frame 3: aborted by reset after 5 handshakes.
        load_frame(16'h0021, 5);
        s_tvalid = 1'b1;
        s_tdata  = 16'h0026;
        rst_n    = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        step();
        rst_n    = 1'b1;
        s_tvalid = 1'b0;
        step();
        @(negedge clk);
        chk("ready_after_abort", 32'(s_tready), 32'd1);
        repeat (5) step();
        chk("abort_no_start", 32'(n_start), 32'd2);
        chk("abort_wq_empty", 32'(wq.size()), 32'd0);

        // Frame 4: full frame after the abort starts again from addr(0).
        load_frame(16'h0031, 8);
        chk_start();
        step();
        rd_base = 32'hC000_0000;
        push_outs(rd_base);
        n_out = 0;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        wait_outputs(8);
        repeat (2) step();
        chk("f4_out_total", 32'(n_out), 32'd8);
        chk("f4_oq_empty", 32'(oq.size()), 32'd0);
        chk("f4_wq_empty", 32'(wq.size()), 32'd0);
        chk("f4_start_count", 32'(n_start), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
